// File: rtl/latch_bus_writer_pkg.sv
// Shared types and timing defaults for the transparent-latch bus writer.
package latch_bus_writer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_SETUP_CYC = 2;
  localparam int unsigned DEF_PULSE_CYC = 2;
  localparam int unsigned DEF_HOLD_CYC  = 1;

  // Wide enough to hold the largest phase length with one bit of margin.
  function automatic int unsigned cnt_width(input int unsigned s,
                                            input int unsigned p,
                                            input int unsigned h);
    int unsigned m;
    m = s;
    if (p > m) m = p;
    if (h > m) m = h;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/latch_bus_writer_phase_timer.sv
// Loadable down-counter timing each writer phase; zero flags phase end.
module latch_bus_writer_phase_timer #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset)
      count <= '0;
    else if (load)
      count <= value;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/latch_bus_writer.sv
// Drives a level-sensitive latch with programmable setup/pulse/hold windows.
// Optional readback compare enabled by LATCH_BUS_WRITER_READBACK_EN.
module latch_bus_writer
  import latch_bus_writer_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
  parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] lat_d,
  output logic              lat_le,
  output logic              busy,
  output logic              done
`ifdef LATCH_BUS_WRITER_READBACK_EN
  ,
  input  logic [DATA_W-1:0] lat_q,
  output logic              rb_err
`endif
);

  localparam int unsigned CNT_W = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);

  if (SETUP_CYC < 1) begin : g_setup_chk
    $error("latch_bus_writer: SETUP_CYC must be at least 1");
  end
  if (PULSE_CYC < 1) begin : g_pulse_chk
    $error("latch_bus_writer: PULSE_CYC must be at least 1");
  end

  state_t           state, state_nx;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             zero;
  logic             accept;

  assign in_ready = reset && (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  latch_bus_writer_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .value(load_val),
    .zero (zero)
  );

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    load_val = '0;
    case (state)
      IDLE: if (accept) begin
        state_nx = SETUP;
        load     = 1'b1;
        load_val = SETUP_LD;
      end
      SETUP: if (zero) begin
        state_nx = STROBE;
        load     = 1'b1;
        load_val = PULSE_LD;
      end
      STROBE: if (zero) begin
        if (HOLD_CYC == 0) begin
          state_nx = IDLE;
        end else begin
          state_nx = HOLD;
          load     = 1'b1;
          load_val = HOLD_LD;
        end
      end
      HOLD: if (zero) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // lat_le and done are decoded from the next state so both are clean registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      lat_d  <= '0;
      lat_le <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      if (accept) lat_d <= in_data;
      lat_le <= (state_nx == STROBE);
      done   <= (state_nx == IDLE) && ((state == STROBE) || (state == HOLD));
    end
  end

`ifdef LATCH_BUS_WRITER_READBACK_EN
  if (HOLD_CYC < 1) begin : g_hold_chk
    $error("latch_bus_writer: readback needs HOLD_CYC of at least 1");
  end

  logic first_hold;

  always_ff @(posedge clk) begin
    if (!reset) begin
      first_hold <= 1'b0;
      rb_err     <= 1'b0;
    end else begin
      first_hold <= (state == STROBE) && (state_nx == HOLD);
      if (first_hold && (lat_q != lat_d)) rb_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_latch_bus_writer.sv
// Scoreboard bench for latch_bus_writer: default timing plus a fast S1/P1/H0 instance.
module tb_latch_bus_writer;

`ifdef LATCH_BUS_WRITER_READBACK_EN
  localparam int NDUT = 1;
`else
  localparam int NDUT = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] in_data[2];
  logic       in_valid[2];
  logic       in_ready[2];
  logic [7:0] lat_d[2];
  logic       lat_le[2];
  logic       busy[2];
  logic       done[2];

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed per-instance shapes: busy cycles, strobe cycles, setup cycles.
  int exp_busy[2]  = '{5, 2};
  int exp_le[2]    = '{2, 1};
  int exp_setup[2] = '{2, 1};

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

`ifdef LATCH_BUS_WRITER_READBACK_EN
  logic [7:0] lat_q;
  logic       rb_err;
  logic       rb_flip = 1'b0;
  assign lat_q = lat_d[0] ^ {7'd0, rb_flip};
`endif

  latch_bus_writer #(
    .DATA_W(8), .SETUP_CYC(2), .PULSE_CYC(2), .HOLD_CYC(1)
  ) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .lat_d(lat_d[0]), .lat_le(lat_le[0]),
    .busy(busy[0]), .done(done[0])
`ifdef LATCH_BUS_WRITER_READBACK_EN
    , .lat_q(lat_q), .rb_err(rb_err)
`endif
  );

`ifndef LATCH_BUS_WRITER_READBACK_EN
  latch_bus_writer #(
    .DATA_W(8), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(0)
  ) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .lat_d(lat_d[1]), .lat_le(lat_le[1]),
    .busy(busy[1]), .done(done[1])
  );
`else
  assign in_ready[1] = 1'b0;
  assign lat_d[1]    = '0;
  assign lat_le[1]   = 1'b0;
  assign busy[1]     = 1'b0;
  assign done[1]     = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [7:0] qfront(input int i);
    return (i == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  // Monitor: tracks each transfer's shape and pops the scoreboard on done.
  int         bcnt[2], lcnt[2], scnt[2];
  logic       prev_le[2];
  logic [7:0] prev_d[2];
  logic [7:0] popped;

  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (reset !== 1'b1) begin
        bcnt[i] = 0; lcnt[i] = 0; scnt[i] = 0; prev_le[i] = 1'b0;
        if (i == 0) exp_q0.delete(); else exp_q1.delete();
      end else begin
        if (lat_le[i] && prev_le[i]) check("d_stable_le", lat_d[i], prev_d[i]);
        if (lat_le[i] && !prev_le[i]) begin
          if (qsize(i) > 0) check("d_at_le_rise", lat_d[i], qfront(i));
          else check("le_without_word", lat_le[i], 0);
        end
        if (busy[i]) begin
          bcnt[i]++;
          if (lat_le[i]) lcnt[i]++;
          else if (lcnt[i] == 0) scnt[i]++;
        end
        if (done[i] === 1'b1) begin
          if (qsize(i) == 0) begin
            check("unexpected_done", done[i], 0);
          end else begin
            popped = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check("done_lat_d", lat_d[i], popped);
            check("busy_cycles", bcnt[i], exp_busy[i]);
            check("strobe_cycles", lcnt[i], exp_le[i]);
            check("setup_cycles", scnt[i], exp_setup[i]);
            check("ready_in_done", in_ready[i], 1);
          end
          bcnt[i] = 0; lcnt[i] = 0; scnt[i] = 0;
        end
        prev_le[i] = lat_le[i];
        prev_d[i]  = lat_d[i];
      end
    end
  end

  // Presents a word, waits (bounded) for acceptance; returns the cycle after the accept edge.
  task automatic send(input int i, input logic [7:0] d, input bit keep, output int unsigned at);
    int unsigned n = 0;
    in_data[i]  = d;
    in_valid[i] = 1'b1;
    while (in_ready[i] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (in_ready[i] !== 1'b1) check("accept_timeout", in_ready[i], 1);
    if (i == 0) exp_q0.push_back(d); else exp_q1.push_back(d);
    @(posedge clk); #1;
    at = cyc;
    if (!keep) in_valid[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, output int unsigned at);
    int unsigned n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (done[i] !== 1'b1 && n < 50);
    check("done_seen", done[i], 1);
    at = cyc;
  endtask

  int unsigned a0, a1, t0;
  int          dcount;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    in_valid = '{1'b1, 1'b1};
    in_data  = '{8'h55, 8'h55};
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_in_ready", in_ready[0], 0);
      check("rst_lat_le", lat_le[0], 0);
      check("rst_busy", busy[0], 0);
      check("rst_done", done[0], 0);
    end
    in_valid = '{1'b0, 1'b0};
    reset    = 1'b1;
    #1;
    check("rel_in_ready", in_ready[0], 1);
    check("rel_lat_d", lat_d[0], 8'h00);
`ifdef LATCH_BUS_WRITER_READBACK_EN
    check("rel_rb_err", rb_err, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_valid", busy[0], 0);

    // Single word at default timing.
    send(0, 8'hA5, 1'b0, a0);
    check("lat_d_after_accept", lat_d[0], 8'hA5);
    wait_done(0, t0);
    check("done_latency", t0 - a0, 5);
    repeat (3) @(posedge clk);
    #1;
    check("lat_d_kept", lat_d[0], 8'hA5);

    // Back-to-back with in_valid held high; data changes while busy.
    send(0, 8'h3C, 1'b1, a0);
    send(0, 8'hC3, 1'b0, a1);
    check("word_period", a1 - a0, 6);
    wait_done(0, t0);

    // Reset during the second strobe cycle.
    repeat (2) @(posedge clk);
    #1;
    send(0, 8'h5A, 1'b0, a0);
    repeat (2) @(posedge clk);
    #1;
    check("le_first_strobe", lat_le[0], 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_lat_le", lat_le[0], 0);
    check("abort_busy", busy[0], 0);
    check("abort_done", done[0], 0);
    reset  = 1'b1;
    dcount = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done[0] === 1'b1) dcount++;
    end
    check("no_done_after_abort", dcount, 0);
    send(0, 8'h77, 1'b0, a0);
    wait_done(0, t0);
    check("post_abort_latency", t0 - a0, 5);

`ifndef LATCH_BUS_WRITER_READBACK_EN
    // Shortest timing, no hold window.
    send(1, 8'hFF, 1'b0, a0);
    check("fast_le_low_setup", lat_le[1], 0);
    @(posedge clk); #1;
    check("fast_le_high", lat_le[1], 1);
    @(posedge clk); #1;
    check("fast_le_fell", lat_le[1], 0);
    check("fast_done", done[1], 1);
    check("fast_done_latency", cyc - a0, 2);
    repeat (2) @(posedge clk);
    #1;
`else
    check("rb_clean_before", rb_err, 0);
    rb_flip = 1'b1;
    send(0, 8'h10, 1'b0, a0);
    wait_done(0, t0);
    check("rb_err_set", rb_err, 1);
    rb_flip = 1'b0;
    send(0, 8'h22, 1'b0, a0);
    wait_done(0, t0);
    check("rb_err_sticky", rb_err, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rb_err_reset", rb_err, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
`endif

    dcount = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && dcount < 20) begin
      @(posedge clk); #1; dcount++;
    end
    check("scoreboard_drained", exp_q0.size() + exp_q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/latch_bus_writer.md
# latch_bus_writer

Transmitting end of a transparent-latch parallel interface: accepts words on a valid/ready input and drives an external level-sensitive latch (data bus plus latch-enable strobe) with programmable setup, enable-pulse and hold windows. It sits between an internal producer and any latch-captured output register, board-level or on-chip. The strobe is a clean registered level, and the data bus never changes while the strobe is high.

## Interface
- DATA_W, 8: word width.
- SETUP_CYC, 2: cycles lat_d is stable before lat_le rises; minimum 1.
- PULSE_CYC, 2: cycles lat_le is high; minimum 1.
- HOLD_CYC, 1: cycles lat_d is held after lat_le falls; minimum 0, or 1 when readback is enabled.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous, active-low.
- in_data  in  DATA_W  word to transmit.
- in_valid  in  1  in_data valid.
- in_ready  out  1  writer can accept a word.
- lat_d  out  DATA_W  registered data bus to the latch.
- lat_le  out  1  registered latch enable, active-high.
- busy  out  1  transfer in progress, meaning state is not IDLE.
- done  out  1  one-cycle pulse when a transfer completes.
- lat_q  in  DATA_W  latch output readback; present only with the readback macro.
- rb_err  out  1  sticky readback mismatch; present only with the readback macro.

## Operation
- FSM states are IDLE, SETUP, STROBE and HOLD. A single down-counter times each phase.
- **IDLE:**
  - in_ready=1.
  - When in_valid&&in_ready, register in_data into lat_d, load counter=SETUP_CYC-1 and go to SETUP.
  - in_data is ignored at all other times.
- **SETUP:** lat_le=0. When the counter reaches 0, go to STROBE with counter=PULSE_CYC-1.
- **STROBE:**
  - lat_le=1.
  - When the counter reaches 0, go to HOLD with counter=HOLD_CYC-1.
  - If HOLD_CYC=0, go directly to IDLE.
- **HOLD:** lat_le=0. When the counter reaches 0, go to IDLE.
- **On entry to IDLE from STROBE or HOLD:** done=1 for exactly that one cycle, and in_ready=1 in the same cycle.
- **lat_d:** changes only on the accept edge. It keeps the last word in IDLE and is never altered while lat_le=1.
- **lat_le:** registered, with no combinational path from any input.
- **busy:** equals (state != IDLE).
- **Counter width:** $clog2 of the largest of SETUP_CYC, PULSE_CYC and HOLD_CYC, plus 1.

## Timing
- **Reset values:** lat_d=0, lat_le=0, in_ready=0 while reset=0, busy=0, done=0, rb_err=0. State is IDLE.
- **Reset mid-transfer:** the first rising edge with reset=0 forces the reset values. An active strobe is truncated (lat_le falls at that edge) and no done pulse is produced.
- **Latency:** with the accept edge as edge 0, lat_le rises at edge SETUP_CYC and falls at edge SETUP_CYC+PULSE_CYC. done is high in the cycle after edge SETUP_CYC+PULSE_CYC+HOLD_CYC.
- **Throughput:** one word per SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles. The next word can be accepted in the done cycle.
- **Defaults:** accept at edge 0, lat_le high after edges 2 and 3, done in the cycle after edge 5, 6 cycles per word.
- **Input handshake:** in_valid held low leaves the block idle indefinitely. An in_valid asserted while busy is not consumed.

## Configuration
- **LATCH_BUS_WRITER_READBACK_EN defined:**
  - lat_q and rb_err ports exist.
  - lat_q is sampled in the first HOLD cycle and compared with lat_d.
  - A mismatch sets rb_err at the next edge. rb_err stays set until reset.
  - HOLD_CYC<1 is an elaboration error.
- **Macro undefined:** no lat_q or rb_err ports, no compare logic, and HOLD_CYC=0 is legal.

## Structure
- **Package latch_bus_writer_pkg:**
  - state typedef enum {IDLE, SETUP, STROBE, HOLD}.
  - Counter-width function.
  - Default timing constants.
- **Sub-module latch_bus_writer_phase_timer:**
  - Loadable down-counter with a zero flag.
  - Instantiated once; the FSM drives load and value.

## Test plan
- **Reset:** hold reset=0 for 3 edges with in_valid=1 -> in_ready=0 and lat_le=0 throughout. Release reset -> in_ready=1 and lat_d=0x00.
- **Single word, defaults:** send 0xA5 -> lat_d=0xA5 from edge 1, lat_le high after edges 2 and 3 only, done one cycle after edge 5, lat_d still 0xA5 afterwards.
- **Back-to-back:** send 0x3C then 0xC3 with in_valid held high -> the second word is accepted in the done cycle, 6 cycles per word, and lat_d never changes while lat_le=1.
- **Reset mid-strobe:** drive reset=0 on the second STROBE cycle -> lat_le=0 and busy=0 at that edge, no done pulse, next accept works normally.
- **HOLD_CYC=0, SETUP_CYC=1, PULSE_CYC=1 with the macro off:** send 0xFF -> lat_le high for one cycle after edge 1, done one cycle after edge 2.
- **Readback, macro on:** tie lat_q=lat_d^0x01 and send 0x10 -> rb_err=1 after the first HOLD cycle and stays 1 through further good transfers until reset.
